// File: rtl/crc32_chk_if.sv
//----------------------------------------------------------------------------
// crc32_chk_if : payload-in / result-out handshake bundle for crc32_chk
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

interface crc32_chk_if #(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32
);
  // Signal suffixes are from the checker's point of view.
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [CRC_WIDTH-1:0]  crc_i;
  logic                  valid_o;
  logic                  ready_i;
  logic                  error_o;
  logic [CRC_WIDTH-1:0]  syndrome_o;

  modport master (
    output valid_i, data_i, crc_i, ready_i,
    input  ready_o, valid_o, error_o, syndrome_o
  );

  modport slave (
    input  valid_i, data_i, crc_i, ready_i,
    output ready_o, valid_o, error_o, syndrome_o
  );
endinterface

`default_nettype wire

// File: rtl/crc32_chk.sv
//----------------------------------------------------------------------------
// crc32_chk : multi-cycle CRC32 checker, optional error counter via CRC32_CHK_ERR_CNT_EN
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

module crc32_chk #(
  parameter int                   DATA_WIDTH     = 512,
  parameter int                   CRC_WIDTH      = 32,
  parameter int                   BITS_PER_CYCLE = 64,
  parameter logic [CRC_WIDTH-1:0] GEN_POLY       = 32'h814141AB
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
`ifdef CRC32_CHK_ERR_CNT_EN
  output logic [15:0]     err_cnt_o,
`endif
  crc32_chk_if.slave      bus
);

  localparam int               BEATS     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int               CNT_W     = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CRC_WIDTH-1:0]  hold_q,  hold_d;
  logic [CRC_WIDTH-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  logic                  ready;
  logic                  valid;
  logic                  accept;
  logic [CRC_WIDTH-1:0]  syndrome;

  // MSB-first bit-serial division, unrolled over one beat.
  function automatic logic [CRC_WIDTH-1:0] fold(
    input logic [CRC_WIDTH-1:0]      acc_in,
    input logic [BITS_PER_CYCLE-1:0] bits
  );
    logic [CRC_WIDTH-1:0] acc;
    acc = acc_in;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      if (acc[CRC_WIDTH-1] != bits[i]) acc = (acc << 1) ^ GEN_POLY;
      else                             acc = acc << 1;
    end
    return acc;
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    valid   = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.valid_i;
      end
      CALC: begin
        acc_d   = fold(acc_q, shreg_q[DATA_WIDTH-1 -: BITS_PER_CYCLE]);
        shreg_d = shreg_q << BITS_PER_CYCLE;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        valid = 1'b1;
        // A consumed result frees the slot, so a new payload may enter now.
        ready = bus.ready_i;
        if (bus.ready_i) begin
          if (bus.valid_i) accept  = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      shreg_d = bus.data_i;
      hold_d  = bus.crc_i;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      hold_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign syndrome       = (state_q == DONE) ? (acc_q ^ hold_q) : '0;
  assign bus.ready_o    = ready;
  assign bus.valid_o    = valid;
  assign bus.syndrome_o = syndrome;
  assign bus.error_o    = |syndrome;

`ifdef CRC32_CHK_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (valid && bus.ready_i && (|syndrome) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc32_chk.sv
//----------------------------------------------------------------------------
// tb_crc32_chk : self-checking bench for crc32_chk against a polynomial-division model
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_crc32_chk;

  localparam int          DW    = 512;
  localparam int          CW    = 32;
  localparam int          BPC   = 64;
  localparam logic [31:0] POLY  = 32'h814141AB;
  localparam int          BEATS = DW / BPC;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   exp_errs;

  crc32_chk_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) bus ();

`ifdef CRC32_CHK_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  crc32_chk #(
    .DATA_WIDTH    (DW),
    .CRC_WIDTH     (CW),
    .BITS_PER_CYCLE(BPC),
    .GEN_POLY      (POLY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CRC32_CHK_ERR_CNT_EN
    .err_cnt_o(err_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of M(x) * x^32 modulo G(x), by long division.
  function automatic logic [31:0] ref_crc(input logic [DW-1:0] d);
    logic [DW+31:0] m;
    m = {d, 32'h0};
    for (int p = DW + 31; p >= 32; p--) begin
      if (m[p]) m[p -: 33] = m[p -: 33] ^ {1'b1, POLY};
    end
    return m[31:0];
  endfunction

  function automatic logic [DW-1:0] rand_payload();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present one payload from IDLE and wait (bounded) for the result.
  task automatic send_frame(input logic [DW-1:0] d, input logic [31:0] c,
                            output int lat, output logic err, output logic [31:0] syn);
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.crc_i   = c;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 0;
    while (bus.valid_o !== 1'b1 && lat < 4 * BEATS) begin
      @(posedge clk); #1;
      lat++;
    end
    err = bus.error_o;
    syn = bus.syndrome_o;
  endtask

  task automatic consume(input logic exp_err);
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    if (exp_err) exp_errs++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready_o);
    else n_pass++;
    n_checks++;
    if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid_o);
    else n_pass++;
    n_checks++;
    if (bus.error_o !== 1'b0) $display("FAIL reset_error: got %b want 0", bus.error_o);
    else n_pass++;
    n_checks++;
    if (bus.syndrome_o !== 32'h0) $display("FAIL reset_syndrome: got %h want 0", bus.syndrome_o);
    else n_pass++;
`ifdef CRC32_CHK_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_vectors();
    logic [DW-1:0] d   [5];
    logic [31:0]   c   [5];
    logic          e   [5];
    logic [31:0]   s   [5];
    int            lat;
    logic          err;
    logic [31:0]   syn;
    d[0] = '0;        c[0] = 32'h0;        e[0] = 1'b0; s[0] = 32'h0;
    d[1] = DW'(1);    c[1] = 32'h814141AB; e[1] = 1'b0; s[1] = 32'h0;
    d[2] = DW'(1);    c[2] = 32'h0;        e[2] = 1'b1; s[2] = 32'h814141AB;
    d[3] = DW'(2);    c[3] = 32'h83C3C2FD; e[3] = 1'b0; s[3] = 32'h0;
    d[4] = DW'(2);    c[4] = 32'h83C3C2FC; e[4] = 1'b1; s[4] = 32'h00000001;
    for (int i = 0; i < 5; i++) begin
      send_frame(d[i], c[i], lat, err, syn);
      n_checks++;
      if (lat != BEATS) $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, BEATS);
      else n_pass++;
      n_checks++;
      if (err !== e[i]) $display("FAIL vec%0d_error: got %b want %b", i, err, e[i]);
      else n_pass++;
      n_checks++;
      if (syn !== s[i]) $display("FAIL vec%0d_syndrome: got %h want %h", i, syn, s[i]);
      else n_pass++;
      consume(e[i]);
      n_checks++;
      if (bus.valid_o !== 1'b0) $display("FAIL vec%0d_valid_drop: got %b want 0", i, bus.valid_o);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1, d2;
    logic [31:0]   c1, c2;
    int            lat;
    logic          err;
    logic [31:0]   syn;
    d1 = rand_payload();
    c1 = ref_crc(d1) ^ 32'h0000_0100;
    d2 = rand_payload();
    c2 = ref_crc(d2);
    send_frame(d1, c1, lat, err, syn);
    n_checks++;
    if (err !== 1'b1 || syn !== 32'h0000_0100)
      $display("FAIL bp_first_result: got err=%b syn=%h want err=1 syn=00000100", err, syn);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.valid_o !== 1'b1 || bus.error_o !== 1'b1 || bus.syndrome_o !== 32'h0000_0100 ||
          bus.ready_o !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b e=%b s=%h r=%b want v=1 e=1 s=00000100 r=0",
                 k, bus.valid_o, bus.error_o, bus.syndrome_o, bus.ready_o);
      else n_pass++;
    end
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = d2;
    bus.crc_i   = c2;
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b1) $display("FAIL bp_ready_follow: got %b want 1", bus.ready_o);
    else n_pass++;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b0;
    exp_errs++;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0)
      $display("FAIL bp_reaccept: got v=%b r=%b want v=0 r=0", bus.valid_o, bus.ready_o);
    else n_pass++;
    lat = 0;
    while (bus.valid_o !== 1'b1 && lat < 4 * BEATS) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != BEATS) $display("FAIL bp_second_latency: got %0d want %0d", lat, BEATS);
    else n_pass++;
    n_checks++;
    if (bus.error_o !== 1'b0 || bus.syndrome_o !== 32'h0)
      $display("FAIL bp_second_result: got e=%b s=%h want e=0 s=0", bus.error_o, bus.syndrome_o);
    else n_pass++;
    consume(1'b0);
  endtask

  task automatic test_reset_mid_calc();
    logic [DW-1:0] d;
    int            lat;
    logic          err;
    logic [31:0]   syn;
    d = rand_payload();
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.crc_i   = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.error_o !== 1'b0 ||
        bus.syndrome_o !== 32'h0)
      $display("FAIL rst_abort: got r=%b v=%b e=%b s=%h want r=1 v=0 e=0 s=0",
               bus.ready_o, bus.valid_o, bus.error_o, bus.syndrome_o);
    else n_pass++;
    exp_errs = 0;
    for (int k = 0; k < BEATS; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      n_checks++;
      if (bus.valid_o !== 1'b0) $display("FAIL rst_no_valid%0d: got %b want 0", k, bus.valid_o);
      else n_pass++;
    end
    d = rand_payload();
    send_frame(d, ref_crc(d) ^ 32'h8000_0000, lat, err, syn);
    n_checks++;
    if (lat != BEATS || err !== 1'b1 || syn !== 32'h8000_0000)
      $display("FAIL rst_next_frame: got lat=%0d e=%b s=%h want lat=%0d e=1 s=80000000",
               lat, err, syn, BEATS);
    else n_pass++;
    consume(1'b1);
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [31:0]   mask;
    logic          corrupt;
    int            lat;
    logic          err;
    logic [31:0]   syn;
    for (int i = 0; i < 1000; i++) begin
      d       = rand_payload();
      corrupt = 1'($urandom_range(0, 1));
      mask    = $urandom;
      if (mask == 32'h0) mask = 32'h1;
      if (!corrupt) mask = 32'h0;
      send_frame(d, ref_crc(d) ^ mask, lat, err, syn);
      n_checks++;
      if (lat != BEATS || err !== corrupt || syn !== mask)
        $display("FAIL rand%0d: got lat=%0d e=%b s=%h want lat=%0d e=%b s=%h",
                 i, lat, err, syn, BEATS, corrupt, mask);
      else n_pass++;
      consume(corrupt);
    end
`ifdef CRC32_CHK_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 16'(exp_errs)) $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_errs);
    else n_pass++;
`endif
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    exp_errs    = 0;
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    bus.crc_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_vectors();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc32_chk.md
# crc32_chk

Sequential CRC32 checker: the receive-side counterpart of the team's combinational CRC32 generator. It accepts a DATA_WIDTH-bit payload together with its transmitted checksum through a valid/ready handshake. It recomputes the CRC over several cycles, processing BITS_PER_CYCLE bits per cycle, then returns a pass/fail flag and a 32-bit syndrome through a second valid/ready handshake. It sits on the DEC receive path behind the link deserializer.

## Interface
- DATA_WIDTH, 512: payload width; must be a nonzero multiple of BITS_PER_CYCLE.
- CRC_WIDTH, 32: checksum width; fixed at 32.
- BITS_PER_CYCLE, 64: payload bits folded into the CRC per CALC cycle.
- GEN_POLY, 32'h814141AB: generator polynomial without the implicit x^32 term; must match the generator.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  payload and checksum are presented.
- ready_o  output  1  checker can accept a payload.
- data_i  input  DATA_WIDTH  payload; the MSB is processed first.
- crc_i  input  CRC_WIDTH  transmitted checksum.
- valid_o  output  1  result is valid.
- ready_i  input  1  downstream consumes the result.
- error_o  output  1  1 = recomputed CRC differs from crc_i.
- syndrome_o  output  CRC_WIDTH  recomputed CRC XOR crc_i; 0 on pass.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE
  - ready_o = 1.
  - On valid_i && ready_o: latch data_i into a shift register and crc_i into a holding register.
  - Clear the CRC accumulator to 0 and the beat counter to 0, then go to CALC.
- CALC
  - Each cycle, apply the single-bit step BITS_PER_CYCLE times, MSB-first, to the accumulator:
    - if acc[31] != d, then acc = (acc << 1) ^ GEN_POLY;
    - else acc = acc << 1.
    - d is the current MSB of the shift register; shift the register left by 1 after each step.
  - There is no init value, no reflection and no final XOR, so the result is bit-identical to the generator.
  - Increment the beat counter. After the beat with counter == DATA_WIDTH/BITS_PER_CYCLE-1, go to DONE.
  - The beat counter is $clog2(DATA_WIDTH/BITS_PER_CYCLE)+1 bits wide.
- DONE
  - valid_o = 1, syndrome_o = acc ^ crc_hold, error_o = |syndrome_o.
  - Outputs hold stable until ready_i is asserted.
  - On ready_i:
    - if valid_i is also high, accept the new payload in the same cycle and go to CALC (ready_o = ready_i in DONE);
    - otherwise go to IDLE.
- ready_o = 0 in CALC. valid_i during CALC is ignored and is not queued.
- error_o and syndrome_o are registered/stable in DONE and driven to 0 in IDLE and CALC.

## Timing
- Reset values: state = IDLE, ready_o = 1, valid_o = 0, error_o = 0, syndrome_o = 0, accumulator = 0, counter = 0.
- Latency: with the accept edge at cycle 0, valid_o rises at cycle N = DATA_WIDTH/BITS_PER_CYCLE (8 with the defaults).
- Throughput: one payload per N+1 cycles with back-to-back acceptance in DONE; the minimum is N+1.
- Asserting rst_n low in CALC or DONE aborts the frame immediately. The result is discarded and no valid_o is produced.
- valid_o never drops without the handshake (ready_i) completing.
- The same rule applies to error_o and syndrome_o: they stay stable until ready_i.

## Configuration
- CRC32_CHK_ERR_CNT_EN
  - Defined: adds the output port err_cnt_o (16 bits, reset 0). It increments by 1 on every DONE handshake (valid_o && ready_i) with error_o = 1, and saturates at 16'hFFFF.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Zero payload: data_i = 0, crc_i = 0 -> valid_o at cycle 8, error_o = 0, syndrome_o = 0.
- data_i = 512'h1, crc_i = 32'h814141AB -> error_o = 0. The same payload with crc_i = 0 -> error_o = 1, syndrome_o = 32'h814141AB.
- data_i = 512'h2, crc_i = 32'h83C3C2FD -> error_o = 0. Flip crc_i bit 0 -> syndrome_o = 32'h00000001.
- Backpressure: hold ready_i = 0 for 5 cycles in DONE -> valid_o, error_o and syndrome_o remain stable, and ready_o = 0. Then ready_i = 1 with valid_i = 1 -> next payload accepted in the same cycle, next valid_o 8 cycles later.
- Reset mid-CALC: assert rst_n low at cycle 4 -> all outputs return to reset values immediately. The next payload gives the correct result.
- Random payloads (≥1000) against the combinational generator model, with 50% corrupted checksums -> error_o matches the corruption exactly. With CRC32_CHK_ERR_CNT_EN defined, err_cnt_o equals the corrupted count.
